// File: rtl/draw_sprite_anim_if.sv
// rtl/draw_sprite_anim_if.sv - pixel/control bundle for the animated sprite address generator (mirror port under SPRITE_MIRROR_EN)
interface draw_sprite_anim_if #(
    parameter int ADDR_W  = 18,
    parameter int FRAME_W = 1
);
    logic               frame_tick;
    logic               pix_valid;
    logic [9:0]         WriteX;
    logic [9:0]         WriteY;
    logic [9:0]         PosX;
    logic [9:0]         PosY;
    logic [1:0]         Game_State;
    logic               Dead;
    logic               alt_skin;
`ifdef SPRITE_MIRROR_EN
    logic               mirror;
`endif
    logic               sprite_on;
    logic [ADDR_W-1:0]  address;
    logic [FRAME_W-1:0] anim_frame;

    modport master (
`ifdef SPRITE_MIRROR_EN
        output mirror,
`endif
        output frame_tick, pix_valid, WriteX, WriteY, PosX, PosY,
        output Game_State, Dead, alt_skin,
        input  sprite_on, address, anim_frame
    );

    modport slave (
`ifdef SPRITE_MIRROR_EN
        input  mirror,
`endif
        input  frame_tick, pix_valid, WriteX, WriteY, PosX, PosY,
        input  Game_State, Dead, alt_skin,
        output sprite_on, address, anim_frame
    );
endinterface

// File: rtl/draw_sprite_anim.sv
// rtl/draw_sprite_anim.sv - 2-stage animated sprite box test and ROM address generator (optional SPRITE_MIRROR_EN)
module draw_sprite_anim #(
    parameter int SPR_W        = 88,
    parameter int SPR_H        = 94,
    parameter int ADDR_W       = 18,
    parameter int N_FRAMES     = 2,
    parameter int HOLD         = 10,
    parameter int BASE_IDLE    = 191323,
    parameter int BASE_RUN     = 207867,
    parameter int BASE_DIE     = 46904,
    parameter int BASE_RUN_ALT = 233303,
    parameter int BASE_DIE_ALT = 249847
) (
    input  logic         Clk,
    input  logic         Reset_n,
    draw_sprite_anim_if.slave bus
);
    localparam int FRAME_W = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
    localparam int HOLD_W  = $clog2(HOLD + 1);
    localparam logic [ADDR_W-1:0] FRAME_WORDS = ADDR_W'(SPR_W * SPR_H);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DEAD} state_t;

    state_t              state_q, state_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;

    logic [9:0]          s1_dx_q, s1_dx_d;
    logic [9:0]          s1_dy_q, s1_dy_d;
    logic                s1_in_box_q, s1_in_box_d;
    logic                s1_valid_q, s1_valid_d;
    logic [ADDR_W-1:0]   s1_base_q, s1_base_d;
`ifdef SPRITE_MIRROR_EN
    logic                s1_mirror_q, s1_mirror_d;
`endif

    logic                on_q, on_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;

    logic [10:0]         wx_e, wy_e, px_e, py_e;
    logic [9:0]          dx_eff;

    // Next state and animation counters; a state change overrides a coincident tick.
    always_comb begin
        state_d = ST_RUN;
        frame_d = frame_q;
        hold_d  = hold_q;
        if (bus.Game_State == 2'b00) begin
            state_d = ST_IDLE;
        end else if (bus.Game_State == 2'b10 || bus.Dead) begin
            state_d = ST_DEAD;
        end
        case (state_d)
            ST_IDLE: begin
                frame_d = '0;
                hold_d  = HOLD_W'(1);
            end
            ST_RUN: begin
                if (state_q != ST_RUN) begin
                    frame_d = '0;
                    hold_d  = HOLD_W'(1);
                end else if (bus.frame_tick) begin
                    if (hold_q == HOLD_W'(HOLD)) begin
                        hold_d  = HOLD_W'(1);
                        frame_d = (frame_q == FRAME_W'(N_FRAMES - 1)) ? '0 : frame_q + FRAME_W'(1);
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
            hold_q  <= HOLD_W'(1);
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            hold_q  <= hold_d;
        end
    end

    // Stage 1: box test on zero-extended 11-bit values so the sprite clips instead of wrapping.
    always_comb begin
        wx_e        = {1'b0, bus.WriteX};
        wy_e        = {1'b0, bus.WriteY};
        px_e        = {1'b0, bus.PosX};
        py_e        = {1'b0, bus.PosY};
        s1_in_box_d = (wx_e >= px_e) && (wx_e < px_e + 11'(SPR_W)) &&
                      (wy_e >= py_e) && (wy_e < py_e + 11'(SPR_H));
        s1_dx_d     = bus.WriteX - bus.PosX;
        s1_dy_d     = bus.WriteY - bus.PosY;
        s1_valid_d  = bus.pix_valid;
`ifdef SPRITE_MIRROR_EN
        s1_mirror_d = bus.mirror;
`endif
        s1_base_d   = ADDR_W'(BASE_IDLE);
        case (state_q)
            ST_RUN:  s1_base_d = (bus.alt_skin ? ADDR_W'(BASE_RUN_ALT) : ADDR_W'(BASE_RUN)) +
                                 ADDR_W'(frame_q) * FRAME_WORDS;
            ST_DEAD: s1_base_d = bus.alt_skin ? ADDR_W'(BASE_DIE_ALT) : ADDR_W'(BASE_DIE);
            default: s1_base_d = ADDR_W'(BASE_IDLE);
        endcase
    end

    // Stage 2: linear ROM address; outside the box the address rests on the base.
    always_comb begin
`ifdef SPRITE_MIRROR_EN
        dx_eff = s1_mirror_q ? (10'(SPR_W - 1) - s1_dx_q) : s1_dx_q;
`else
        dx_eff = s1_dx_q;
`endif
        on_d   = s1_in_box_q & s1_valid_q;
        addr_d = s1_base_q;
        if (s1_in_box_q) begin
            addr_d = s1_base_q + ADDR_W'(s1_dy_q) * ADDR_W'(SPR_W) + ADDR_W'(dx_eff);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_dx_q     <= '0;
            s1_dy_q     <= '0;
            s1_in_box_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_base_q   <= '0;
`ifdef SPRITE_MIRROR_EN
            s1_mirror_q <= 1'b0;
`endif
            on_q        <= 1'b0;
            addr_q      <= '0;
        end else begin
            s1_dx_q     <= s1_dx_d;
            s1_dy_q     <= s1_dy_d;
            s1_in_box_q <= s1_in_box_d;
            s1_valid_q  <= s1_valid_d;
            s1_base_q   <= s1_base_d;
`ifdef SPRITE_MIRROR_EN
            s1_mirror_q <= s1_mirror_d;
`endif
            on_q        <= on_d;
            addr_q      <= addr_d;
        end
    end

    assign bus.sprite_on  = on_q;
    assign bus.address    = addr_q;
    assign bus.anim_frame = frame_q;
endmodule

// File: tb/tb_draw_sprite_anim.sv
// tb/tb_draw_sprite_anim.sv - table, directed and randomized checks of draw_sprite_anim against a reference model
module tb_draw_sprite_anim;
    localparam int ADDR_W = 18;
    localparam int SPR_W  = 88;
    localparam int SPR_H  = 94;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    draw_sprite_anim_if #(.ADDR_W(ADDR_W), .FRAME_W(1)) bus ();
    draw_sprite_anim dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode 0 idle, 1 run, 2 dead; p1/p2 are pixels one and two clocks old.
    int m_mode, m_frame, m_hold;
    int p1_on, p1_addr, p2_on, p2_addr;

    typedef struct {
        logic [1:0] gs;
        logic       dead;
        logic       alt;
        int         px, py, wx, wy;
        int         exp_on;
        int         exp_addr;
    } vec_t;
    vec_t vecs[14];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_frame = 0; m_hold = 1;
        p1_on = 0; p1_addr = 0; p2_on = 0; p2_addr = 0;
    endtask

    task automatic model_edge();
        int base, x, y, px, py, dx, addr, inb, nm;
        if (!Reset_n) begin
            model_reset();
            return;
        end
        if (m_mode == 0)      base = 191323;
        else if (m_mode == 2) base = bus.alt_skin ? 249847 : 46904;
        else                  base = (bus.alt_skin ? 233303 : 207867) + m_frame * SPR_W * SPR_H;
        x = bus.WriteX; y = bus.WriteY; px = bus.PosX; py = bus.PosY;
        inb = (x >= px && x < px + SPR_W && y >= py && y < py + SPR_H) ? 1 : 0;
        dx = x - px;
`ifdef SPRITE_MIRROR_EN
        if (bus.mirror) dx = SPR_W - 1 - dx;
`endif
        addr = inb ? ((base + (y - py) * SPR_W + dx) % (1 << ADDR_W)) : base;
        p2_on = p1_on; p2_addr = p1_addr;
        p1_on = inb & bus.pix_valid; p1_addr = addr;
        if (bus.Game_State == 2'b00)                    nm = 0;
        else if (bus.Game_State == 2'b10 || bus.Dead)   nm = 2;
        else                                            nm = 1;
        if (nm == 0) begin
            m_frame = 0; m_hold = 1;
        end else if (nm == 1) begin
            if (m_mode != 1) begin
                m_frame = 0; m_hold = 1;
            end else if (bus.frame_tick) begin
                if (m_hold == 10) begin
                    m_frame = (m_frame + 1) % 2; m_hold = 1;
                end else begin
                    m_hold++;
                end
            end
        end
        m_mode = nm;
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
        check("model_sprite_on", bus.sprite_on, p2_on);
        check("model_address", bus.address, p2_addr);
        check("model_anim_frame", bus.anim_frame, m_frame);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_tick = 1'b1;
            step();
            bus.frame_tick = 1'b0;
            step();
        end
    endtask

    task automatic set_pix(input int px, input int py, input int wx, input int wy);
        bus.PosX = 10'(px); bus.PosY = 10'(py);
        bus.WriteX = 10'(wx); bus.WriteY = 10'(wy);
    endtask

    task automatic expect_out(input string nm, input int on, input int addr);
        check({nm, "_on"}, bus.sprite_on, on);
        check({nm, "_addr"}, bus.address, addr);
    endtask

    initial begin
        vecs[0]  = '{2'b01, 1'b0, 1'b0, 100, 50, 100, 50, 1, 207867};
        vecs[1]  = '{2'b01, 1'b0, 1'b0, 100, 50, 187, 143, 1, 216138};
        vecs[2]  = '{2'b01, 1'b0, 1'b0, 100, 50, 188, 50, 0, 207867};
        vecs[3]  = '{2'b01, 1'b0, 1'b0, 100, 50, 100, 49, 0, 207867};
        vecs[4]  = '{2'b01, 1'b0, 1'b0, 100, 50, 187, 144, 0, 207867};
        vecs[5]  = '{2'b01, 1'b0, 1'b0, 100, 50, 99, 143, 0, 207867};
        vecs[6]  = '{2'b00, 1'b0, 1'b0, 100, 50, 100, 50, 1, 191323};
        vecs[7]  = '{2'b10, 1'b0, 1'b0, 100, 50, 100, 50, 1, 46904};
        vecs[8]  = '{2'b01, 1'b1, 1'b1, 100, 50, 110, 60, 1, 250737};
        vecs[9]  = '{2'b11, 1'b0, 1'b1, 100, 50, 100, 51, 1, 233391};
        vecs[10] = '{2'b01, 1'b0, 1'b0, 1000, 1000, 1023, 1023, 1, 209914};
        vecs[11] = '{2'b01, 1'b0, 1'b0, 1000, 1000, 0, 1000, 0, 207867};
        vecs[12] = '{2'b01, 1'b0, 1'b0, 1000, 0, 1023, 93, 1, 216074};
        vecs[13] = '{2'b01, 1'b0, 1'b0, 1000, 0, 1023, 94, 0, 207867};

        bus.frame_tick = 1'b0; bus.pix_valid = 1'b1; bus.Game_State = 2'b01;
        bus.Dead = 1'b0; bus.alt_skin = 1'b0;
`ifdef SPRITE_MIRROR_EN
        bus.mirror = 1'b0;
`endif
        set_pix(100, 50, 100, 50);
        model_reset();

        // Reset holds outputs at zero, even across frame ticks.
        #1;
        expect_out("reset", 0, 0);
        check("reset_anim", bus.anim_frame, 0);
        ticks(3);
        expect_out("reset_ticks", 0, 0);
        check("reset_ticks_anim", bus.anim_frame, 0);
        Reset_n = 1'b1;
        step();

        for (int i = 0; i < 14; i++) begin
            bus.Game_State = vecs[i].gs; bus.Dead = vecs[i].dead; bus.alt_skin = vecs[i].alt;
            set_pix(vecs[i].px, vecs[i].py, vecs[i].wx, vecs[i].wy);
            for (int k = 0; k < 4; k++) step();
            expect_out($sformatf("vec%0d", i), vecs[i].exp_on, vecs[i].exp_addr);
        end

        // Animation sequence, death freeze, skin swap, idle and pix_valid.
        bus.Game_State = 2'b00; bus.Dead = 1'b0; bus.alt_skin = 1'b0;
        set_pix(100, 50, 100, 50);
        step(); step();
        bus.Game_State = 2'b01;
        step(); step(); step();
        expect_out("run_f0", 1, 207867);
        ticks(10);
        step(); step();
        check("anim_after10", bus.anim_frame, 1);
        expect_out("run_f1", 1, 216139);
        ticks(10);
        step(); step();
        check("anim_wrap", bus.anim_frame, 0);
        expect_out("run_wrap", 1, 207867);
        ticks(15);
        bus.Dead = 1'b1;
        step(); step(); step();
        expect_out("dead", 1, 46904);
        ticks(30);
        check("dead_frozen", bus.anim_frame, 1);
        bus.alt_skin = 1'b1;
        step(); step(); step();
        expect_out("dead_alt", 1, 249847);
        bus.Dead = 1'b0;
        step(); step(); step();
        check("revive_anim", bus.anim_frame, 0);
        expect_out("revive_alt", 1, 233303);
        bus.Game_State = 2'b00; bus.alt_skin = 1'b0;
        step(); step(); step();
        expect_out("idle", 1, 191323);
        check("idle_anim", bus.anim_frame, 0);
        bus.pix_valid = 1'b0;
        step(); step(); step();
        check("novalid_on", bus.sprite_on, 0);
        bus.pix_valid = 1'b1;

        // Asynchronous mid-line reset and the two-clock refill afterwards.
        bus.Game_State = 2'b01;
        step(); step(); step();
        Reset_n = 1'b0;
        model_reset();
        #1;
        expect_out("midreset", 0, 0);
        step();
        Reset_n = 1'b1;
        step();
        check("refill1_on", bus.sprite_on, 0);
        step();
        expect_out("refill2", 1, 191323);

`ifdef SPRITE_MIRROR_EN
        bus.mirror = 1'b1;
        set_pix(100, 50, 100, 50);
        step(); step(); step();
        expect_out("mirror_left", 1, 207954);
        set_pix(100, 50, 187, 50);
        step(); step();
        expect_out("mirror_right", 1, 207867);
        bus.mirror = 1'b0;
`endif

        // Randomized traffic around the sprite, checked by the model on every clock.
        for (int c = 0; c < 4000; c++) begin
            int px, py;
            if ($urandom_range(0, 39) == 0) bus.Game_State = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 199) == 0) bus.Game_State = 2'b00;
            if ($urandom_range(0, 59) == 0) bus.Dead = ~bus.Dead;
            if ($urandom_range(0, 99) == 0) bus.alt_skin = ~bus.alt_skin;
`ifdef SPRITE_MIRROR_EN
            if ($urandom_range(0, 79) == 0) bus.mirror = ~bus.mirror;
`endif
            bus.frame_tick = ($urandom_range(0, 2) == 0);
            bus.pix_valid = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 49) == 0) begin
                bus.PosX = 10'($urandom_range(0, 1023));
                bus.PosY = 10'($urandom_range(0, 1023));
            end
            px = bus.PosX; py = bus.PosY;
            bus.WriteX = 10'(px + $urandom_range(0, 100) - 6);
            bus.WriteY = 10'(py + $urandom_range(0, 106) - 6);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
